// File: rtl/present_round_state_reg_if.sv
// present_round_state_reg_if
//   Groups the handshake and data signals of the PRESENT round-state register.
//   Ports (all carried as interface members):
//     in_valid/in_ready/in_data      : plaintext load handshake
//     stall                          : freezes RUN progress
//     round_data                     : next state from the external round function
//     state_q/round_cnt              : registered state and round number to the round function
//     busy                           : block is iterating rounds
//     out_valid/out_ready/out_data   : result hand-off handshake
//   master = plaintext source / round function / consumer side; slave = the register block.
interface present_round_state_reg_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic [WIDTH-1:0] round_data;
  logic [WIDTH-1:0] state_q;
  logic [CNT_W-1:0] round_cnt;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, stall, round_data, out_ready,
    input  in_ready, state_q, round_cnt, busy, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, stall, round_data, out_ready,
    output in_ready, state_q, round_cnt, busy, out_valid, out_data
  );
endinterface

// File: rtl/present_round_state_reg.sv
// present_round_state_reg
//   Holds the PRESENT cipher state across iterative rounds: loads a plaintext
//   in IDLE, applies the external round function ROUNDS times in RUN (freezable
//   by stall), and presents the final state in DONE until the consumer takes it.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : slave side of present_round_state_reg_if (handshakes, state, round counter)
//   All outputs are decoded from registers only.
module present_round_state_reg #(
  parameter int WIDTH  = 64,
  parameter int ROUNDS = 31,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  present_round_state_reg_if.slave  bus
);

  // Counter must reach ROUNDS without wrapping.
  if (ROUNDS < 1 || (64'd1 << CNT_W) <= 64'(ROUNDS)) begin : g_param_check
    $error("present_round_state_reg: need ROUNDS >= 1 and 2**CNT_W > ROUNDS");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d     = bus.in_data;
          round_cnt_d = CNT_W'(1);
          fsm_d       = RUN;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          state_d = bus.round_data;
          // The last round leaves the counter at ROUNDS so it never wraps.
          if (round_cnt_q == CNT_W'(ROUNDS)) begin
            fsm_d = DONE;
          end else begin
            round_cnt_d = round_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          round_cnt_d = '0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.busy      = (fsm_q == RUN);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.state_q   = state_q;
  assign bus.round_cnt = round_cnt_q;
  assign bus.out_data  = state_q;

endmodule

// File: tb/tb_present_round_state_reg.sv
module tb_present_round_state_reg;
  localparam int WIDTH  = 64;
  localparam int ROUNDS = 31;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  present_round_state_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  present_round_state_reg #(.WIDTH(WIDTH), .ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint prev_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PRESENT reference pieces: S-box, round function, 80-bit key schedule (key 0)
  logic [3:0]  SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rk [0:32];
  bit          stub = 1'b1;

  function automatic logic [63:0] pr(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t, u, o;
    t = s ^ k;
    for (int n = 0; n < 16; n++) u[n*4 +: 4] = SB[t[n*4 +: 4]];
    o = '0;
    for (int i = 0; i < 63; i++) o[(i * 16) % 63] = u[i];
    o[63] = u[63];
    return o;
  endfunction

  always_comb begin
    bus.round_data = stub ? bus.state_q + 64'd1 : pr(bus.state_q, rk[bus.round_cnt]);
  end

  // Scoreboard: expected results queued at accept, popped on output handshake
  logic [63:0] sb [$];
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", bus.out_data);
      end else begin
        chk("sb_out_data", bus.out_data, sb.pop_front());
      end
    end
  end

  typedef struct {
    logic [63:0] din;
    bit          use_stub;
    int          stall_at;
    int          stall_len;
    int          bp;
    bit          hold_valid;
    bit          b2b;
    logic [63:0] exp;
  } vec_t;

  vec_t tv [5];

  // Called at posedge+1 while the DUT is in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_block(input vec_t v);
    int          cnt_exp, stalls_left, lat;
    longint      acc;
    logic [63:0] held;
    stub          = v.use_stub;
    bus.in_data   = v.din;
    bus.in_valid  = 1'b1;
    bus.stall     = 1'b0;
    bus.out_ready = (v.bp == 0);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    sb.push_back(v.exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc = cyc;
    if (v.b2b) chk("accept_spacing", 64'(acc - prev_acc), 64'(ROUNDS + 2));
    prev_acc    = acc;
    cnt_exp     = 1;
    stalls_left = v.stall_len;
    lat         = 0;
    while (!bus.out_valid && lat < 200) begin
      chk("run_round_cnt", 64'(bus.round_cnt), 64'(cnt_exp));
      chk("run_busy", 64'(bus.busy), 64'd1);
      if (cnt_exp == v.stall_at && stalls_left > 0) begin
        bus.stall = 1'b1;
        stalls_left--;
      end else begin
        bus.stall = 1'b0;
        if (cnt_exp < ROUNDS) cnt_exp++;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.stall = 1'b0;
    chk("latency", 64'(lat), 64'(ROUNDS + v.stall_len));
    chk("done_busy", 64'(bus.busy), 64'd0);
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    chk("done_round_cnt", 64'(bus.round_cnt), 64'(ROUNDS));
    held = bus.out_data;
    chk("done_out_data", held, v.exp);
    if (v.hold_valid) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hDEAD_BEEF_0000_0001;
    end
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data", bus.out_data, held);
      chk("bp_round_cnt", 64'(bus.round_cnt), 64'(ROUNDS));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("exit_out_valid", 64'(bus.out_valid), 64'd0);
    chk("exit_round_cnt", 64'(bus.round_cnt), 64'd0);
    chk("exit_in_ready", 64'(bus.in_ready), 64'd1);
    chk("exit_state_q", bus.state_q, v.exp);
  endtask

  initial begin
    logic [79:0] k;
    int          n;
    k = '0;
    for (int i = 1; i <= 32; i++) begin
      rk[i]       = k[79:16];
      k           = {k[18:0], k[79:19]};
      k[79:76]    = SB[k[79:76]];
      k[19:15]    = k[19:15] ^ 5'(i);
    end
    rk[0] = '0;

    // Reset with random inputs for two edges
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = {$urandom, $urandom};
      bus.stall     = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_state_q", bus.state_q, 64'd0);
    chk("rst_round_cnt", 64'(bus.round_cnt), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.stall     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold_state_q", bus.state_q, 64'd0);

    // Reset in the middle of RUN discards the block
    stub         = 1'b1;
    bus.in_data  = 64'h55;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.round_cnt != 5'd12 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reach_12", 64'(bus.round_cnt), 64'd12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_state_q", bus.state_q, 64'd0);
    chk("midrst_round_cnt", 64'(bus.round_cnt), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
    end

    // Vector table
    tv[0] = '{din: 64'hFFFF, use_stub: 1'b1, stall_at: 0, stall_len: 0, bp: 4,
              hold_valid: 1'b1, b2b: 1'b0, exp: 64'h1001E};
    tv[1] = '{din: 64'h0, use_stub: 1'b0, stall_at: 0, stall_len: 0, bp: 0,
              hold_valid: 1'b0, b2b: 1'b0, exp: 64'h5579C1387B228445 ^ rk[32]};
    tv[2] = '{din: 64'h10, use_stub: 1'b1, stall_at: 5, stall_len: 3, bp: 0,
              hold_valid: 1'b0, b2b: 1'b0, exp: 64'h2F};
    tv[3] = '{din: 64'h1234_5678_9ABC_DEF0, use_stub: 1'b1, stall_at: 0, stall_len: 0, bp: 0,
              hold_valid: 1'b1, b2b: 1'b0, exp: 64'h1234_5678_9ABC_DF0F};
    tv[4] = '{din: 64'hFFFF_FFFF_FFFF_FFF0, use_stub: 1'b1, stall_at: 0, stall_len: 0, bp: 0,
              hold_valid: 1'b0, b2b: 1'b1, exp: 64'h0000_0000_0000_000F};
    for (int i = 0; i < 5; i++) begin
      run_block(tv[i]);
      if (!tv[i].use_stub) chk("ciphertext", bus.state_q ^ rk[32], 64'h5579C1387B228445);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("end_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/present_round_state_reg.md
Name: present_round_state_reg

Overview:
- Parametrised successor to the plain enabled 64-bit data register: holds the PRESENT cipher state across iterative rounds.
- Sequences the state through load, round iteration and result hand-off.
- Adds a round counter (drives the key schedule), stall control and valid/ready handshakes on input and output.
- Sits between the plaintext source, the external combinational round function (addRoundKey/sLayer/pLayer) and the final-key-add/output stage of the round-based core.

Parameters:
- WIDTH, 64: state width in bits.
- ROUNDS, 31: number of round-function applications per block; must be at least 1.
- CNT_W, 5: round counter width; constraint 2**CNT_W > ROUNDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a new state; high only in IDLE.
- in_data  input  WIDTH  initial state (plaintext).
- stall  input  1  freezes the state and the counter in RUN.
- round_data  input  WIDTH  next state from the external round function, computed from state_q and round_cnt.
- state_q  output  WIDTH  registered cipher state; feeds the round function.
- round_cnt  output  CNT_W  current round number, 1..ROUNDS; 0 in IDLE.
- busy  output  1  high in RUN.
- out_valid  output  1  out_data holds the final state; high in DONE.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  equals state_q.

Behaviour:
- Reset and priority:
  - rst sampled at a rising edge: FSM goes to IDLE, state_q=0, round_cnt=0, out_valid=0, busy=0, in_ready=1 after that edge.
  - rst overrides every other input, including mid-RUN and mid-DONE; the in-flight block is discarded with no output.
- FSM states: IDLE, RUN, DONE. All outputs are decoded from registers; there is no combinational path from any input to any output.
- IDLE:
  - in_ready=1.
  - Edge with in_valid=1: state_q<=in_data, round_cnt<=1, go to RUN.
  - Otherwise state_q and round_cnt hold.
  - stall is ignored.
- RUN:
  - in_ready=0, busy=1. in_valid is ignored; no data is lost because the source must see in_ready=0.
  - Edge with stall=1: state_q, round_cnt and the FSM state all hold.
  - Edge with stall=0 and round_cnt<ROUNDS: state_q<=round_data, round_cnt<=round_cnt+1.
  - Edge with stall=0 and round_cnt==ROUNDS: state_q<=round_data, round_cnt holds at ROUNDS, go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - state_q holds until an edge with out_ready=1; then go to IDLE with round_cnt<=0. state_q keeps its last value in IDLE.
  - stall and round_data are ignored.
- Latency:
  - Accept edge E0; rounds are applied at edges E1..E(ROUNDS).
  - out_valid rises after E(ROUNDS) when there are no stalls.
  - Each stalled cycle adds exactly 1 cycle.
  - Minimum accept-to-accept period is ROUNDS+2 edges (includes the DONE hand-off and one IDLE cycle).
- Boundary cases:
  - ROUNDS=1: RUN lasts one unstalled edge.
  - round_cnt never wraps and never exceeds ROUNDS.
  - out_ready held high throughout: DONE lasts exactly one cycle.
  - in_valid high in DONE: not accepted until IDLE.

Test Plan:
- Reset then idle: assert rst 2 cycles with random inputs -> state_q=0, round_cnt=0, out_valid=0, busy=0, in_ready=1.
- Full block, no stall, out_ready=1: in_data=64'h0000000000000000 with the real PRESENT-80 round function and final key add driven externally from key 0 -> out_valid high exactly 31 edges after accept; round_cnt shows 1..31 in sequence; ciphertext 64'h5579C1387B228445.
- Stall mid-run: stub round_data=state_q+1, load 64'h10, stall for 3 cycles at round_cnt=5 -> round_cnt stays 5 for 3 cycles; out_valid after 34 edges; out_data=64'h10+31=64'h2F.
- Output back-pressure: finish a block with out_ready=0 for 4 cycles, then pulse it -> out_valid and out_data stable for 5 cycles; return to IDLE with round_cnt=0; in_valid held high in DONE not accepted until IDLE.
- Reset mid-operation: assert rst at round_cnt=12 -> IDLE next cycle, no out_valid pulse; the next block 64'hFFFF with the +1 stub yields 64'h1001E.
- Back-to-back blocks: in_valid held high with two different inputs -> second accepted one cycle after DONE exits; each result correct; accepts spaced ROUNDS+2 edges apart.
